// File: rtl/list_mgr_pkg.sv
// Shared definitions for the RTOS list manager stages (insert_item / remove_item):
// widths, item and priority-entry field layout, FSM encodings and packing helpers.
package list_mgr_pkg;

    localparam int ID_W    = 8;
    localparam int PRI_W   = 6;
    localparam int TADDR_W = 32;
    localparam int ELEM_W  = 8;

    // Item entry: {addr, pri, prev, next}
    localparam int ITEM_NEXT_LSB = 0;
    localparam int ITEM_PREV_LSB = ITEM_NEXT_LSB + ID_W;
    localparam int ITEM_PRI_LSB  = ITEM_PREV_LSB + ID_W;
    localparam int ITEM_ADDR_LSB = ITEM_PRI_LSB + PRI_W;
    localparam int ITEM_W        = ITEM_ADDR_LSB + TADDR_W;

    // Priority entry: {strt, end, elements}
    localparam int PRIO_ELEM_LSB = 0;
    localparam int PRIO_END_LSB  = PRIO_ELEM_LSB + ELEM_W;
    localparam int PRIO_STRT_LSB = PRIO_END_LSB + ID_W;
    localparam int PRIO_W        = PRIO_STRT_LSB + ID_W;

    localparam logic [ELEM_W-1:0] MAX_ELEMENTS = 8'd255;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_NEW  = 3'd1,
        WR_TAIL = 3'd2,
        WR_HEAD = 3'd3,
        WR_PRI  = 3'd4
    } ins_state_t;

    function automatic logic [ITEM_W-1:0] pack_item(
        input logic [TADDR_W-1:0] addr,
        input logic [PRI_W-1:0]   pri,
        input logic [ID_W-1:0]    prev,
        input logic [ID_W-1:0]    next
    );
        return {addr, pri, prev, next};
    endfunction

    function automatic logic [PRIO_W-1:0] pack_prio(
        input logic [ID_W-1:0]   strt,
        input logic [ID_W-1:0]   last,
        input logic [ELEM_W-1:0] elements
    );
        return {strt, last, elements};
    endfunction

endpackage

// File: rtl/insert_item_if.sv
// Request and shared-RAM signal bundle for the insert_item list manager stage.
interface insert_item_if;
    import list_mgr_pkg::*;

    logic                 enable;
    logic [ID_W-1:0]      idtask_in;
    logic [PRI_W-1:0]     priority_in;
    logic [TADDR_W-1:0]   addrtask_in;
    logic                 busy_out;
    logic                 done_out;
    logic                 pri_insert;
    logic                 err_out;
    logic [ID_W-1:0]      addr_itemlist;
    logic                 we_itemlist;
    logic [ITEM_W-1:0]    data_itemlist;
    logic [ITEM_W-1:0]    spo_itemlist;
    logic [PRI_W-1:0]     addr_prioritylist;
    logic                 we_prioritylist;
    logic [PRIO_W-1:0]    data_prioritylist;
    logic [PRIO_W-1:0]    spo_prioritylist;

    // The list manager stage itself
    modport slave (
        input  enable, idtask_in, priority_in, addrtask_in,
        input  spo_itemlist, spo_prioritylist,
        output busy_out, done_out, pri_insert, err_out,
        output addr_itemlist, we_itemlist, data_itemlist,
        output addr_prioritylist, we_prioritylist, data_prioritylist
    );

    // Requester plus RAM side
    modport master (
        output enable, idtask_in, priority_in, addrtask_in,
        output spo_itemlist, spo_prioritylist,
        input  busy_out, done_out, pri_insert, err_out,
        input  addr_itemlist, we_itemlist, data_itemlist,
        input  addr_prioritylist, we_prioritylist, data_prioritylist
    );

endinterface

// File: rtl/insert_item.sv
// Appends a task to the tail of its priority's circular doubly-linked ready list.
// Sequence: write the new item, patch the old tail's next, patch the head's prev,
// then update the priority entry. Empty lists skip the two patch cycles.
module insert_item
    import list_mgr_pkg::*;
(
    input  logic          aclk,
    input  logic          aresetn,
    insert_item_if.slave  bus
);

    ins_state_t          state_r, next_state_s;
    logic [ID_W-1:0]     id_r;
    logic [PRI_W-1:0]    pri_r;
    logic [TADDR_W-1:0]  taddr_r;
    logic [ID_W-1:0]     strt_r;
    logic [ID_W-1:0]     end_r;
    logic [ELEM_W-1:0]   elem_r;

    logic [ID_W-1:0]     strt_spo_s;
    logic [ID_W-1:0]     end_spo_s;
    logic [ELEM_W-1:0]   elem_spo_s;
    logic                accept_s;
    logic                list_full_s;

    assign strt_spo_s  = bus.spo_prioritylist[PRIO_STRT_LSB +: ID_W];
    assign end_spo_s   = bus.spo_prioritylist[PRIO_END_LSB  +: ID_W];
    assign elem_spo_s  = bus.spo_prioritylist[PRIO_ELEM_LSB +: ELEM_W];
    assign list_full_s = (elem_spo_s == MAX_ELEMENTS);
    assign accept_s    = (state_r == IDLE) && bus.enable && !list_full_s;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture at acceptance; inputs may change once latched
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            id_r    <= '0;
            pri_r   <= '0;
            taddr_r <= '0;
            strt_r  <= '0;
            end_r   <= '0;
            elem_r  <= '0;
        end else if (accept_s) begin
            id_r    <= bus.idtask_in;
            pri_r   <= bus.priority_in;
            taddr_r <= bus.addrtask_in;
            strt_r  <= strt_spo_s;
            end_r   <= end_spo_s;
            elem_r  <= elem_spo_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = WR_NEW;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WR_NEW: begin
                if (elem_r == 8'd0) begin
                    next_state_s = WR_PRI;
                end else begin
                    next_state_s = WR_TAIL;
                end
            end
            WR_TAIL: next_state_s = WR_HEAD;
            WR_HEAD: next_state_s = WR_PRI;
            WR_PRI:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output and RAM-port muxing per state
    always_comb begin
        bus.busy_out          = 1'b1;
        bus.done_out          = 1'b0;
        bus.pri_insert        = 1'b0;
        bus.err_out           = 1'b0;
        bus.addr_itemlist     = id_r;
        bus.we_itemlist       = 1'b0;
        bus.data_itemlist     = '0;
        bus.addr_prioritylist = pri_r;
        bus.we_prioritylist   = 1'b0;
        bus.data_prioritylist = '0;
        case (state_r)
            IDLE: begin
                bus.busy_out          = 1'b0;
                bus.addr_itemlist     = bus.idtask_in;
                bus.addr_prioritylist = bus.priority_in;
                if (bus.enable && list_full_s) begin
                    bus.err_out = 1'b1;
                end else if (bus.enable && (elem_spo_s == 8'd0)) begin
                    bus.pri_insert = 1'b1;
                end else begin
                    bus.err_out = 1'b0;
                end
            end
            WR_NEW: begin
                bus.addr_itemlist = id_r;
                bus.we_itemlist   = 1'b1;
                if (elem_r == 8'd0) begin
                    bus.data_itemlist = pack_item(taddr_r, pri_r, id_r, id_r);
                end else begin
                    bus.data_itemlist = pack_item(taddr_r, pri_r, end_r, strt_r);
                end
            end
            WR_TAIL: begin
                // Read-modify-write of the old tail: only next changes
                bus.addr_itemlist = end_r;
                bus.we_itemlist   = 1'b1;
                bus.data_itemlist = bus.spo_itemlist;
                bus.data_itemlist[ITEM_NEXT_LSB +: ID_W] = id_r;
            end
            WR_HEAD: begin
                // For a one-element list head==tail, so this sees the WR_TAIL result
                bus.addr_itemlist = strt_r;
                bus.we_itemlist   = 1'b1;
                bus.data_itemlist = bus.spo_itemlist;
                bus.data_itemlist[ITEM_PREV_LSB +: ID_W] = id_r;
            end
            WR_PRI: begin
                bus.addr_prioritylist = pri_r;
                bus.we_prioritylist   = 1'b1;
                bus.done_out          = 1'b1;
                if (elem_r == 8'd0) begin
                    bus.data_prioritylist = pack_prio(id_r, id_r, 8'd1);
                end else begin
                    bus.data_prioritylist = pack_prio(strt_r, id_r, elem_r + 8'd1);
                end
            end
            default: begin
                bus.busy_out = 1'b0;
            end
        endcase
    end

endmodule
